// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad front end: walks a low row across the matrix, debounces a single key press
// and release, and reports each accepted press as a code with a one-cycle strobe.
module keypad_scan_debounce #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW  = $clog2(SCAN_DIV);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

    state_t         state, state_nx;
    logic [3:0]     col_m, col_s;
    logic [1:0]     row_idx, row_idx_nx;
    logic [DW-1:0]  dwell_cnt, dwell_nx;
    logic [DBW-1:0] db_cnt, db_nx;
    logic [3:0]     cand, cand_nx;
    logic [3:0]     code_nx;
    logic           valid_nx, held_nx;
    logic [2:0]     low_cnt;
    logic [1:0]     low_idx;
    logic [3:0]     cand_pat;

    // key_valid is a bare strobe: no ready/backpressure, the consumer must take it in that cycle.
    assign row      = ~(4'b0001 << row_idx);
    assign cand_pat = ~(4'b0001 << cand[1:0]);

    always_comb begin
        low_cnt = 3'd0;
        low_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!col_s[i]) begin
                low_cnt = low_cnt + 3'd1;
                low_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_nx   = state;
        row_idx_nx = row_idx;
        dwell_nx   = dwell_cnt;
        db_nx      = db_cnt;
        cand_nx    = cand;
        code_nx    = key_code;
        valid_nx   = 1'b0;
        held_nx    = key_held;
        case (state)
            SCAN: begin
                // Columns are judged only at the end of the dwell so the synchronizer has caught up with the row change.
                if (dwell_cnt == DWELL_LAST) begin
                    dwell_nx = '0;
                    if (low_cnt == 3'd1) begin
                        cand_nx  = {row_idx, low_idx};
                        db_nx    = '0;
                        state_nx = PRESS_DB;
                    end else begin
                        row_idx_nx = row_idx + 2'd1;
                    end
                end else begin
                    dwell_nx = dwell_cnt + 1'b1;
                end
            end
            PRESS_DB: begin
                if (col_s != cand_pat) begin
                    state_nx = SCAN;
                    dwell_nx = '0;
                    db_nx    = '0;
                end else if (db_cnt == DB_LAST) begin
                    code_nx  = cand;
                    valid_nx = 1'b1;
                    held_nx  = 1'b1;
                    db_nx    = '0;
                    state_nx = HELD;
                end else begin
                    db_nx = db_cnt + 1'b1;
                end
            end
            HELD: begin
                if (col_s == 4'b1111) begin
                    db_nx    = '0;
                    state_nx = REL_DB;
                end
            end
            REL_DB: begin
                if (col_s != 4'b1111) begin
                    state_nx = HELD;
                end else if (db_cnt == DB_LAST) begin
                    held_nx    = 1'b0;
                    row_idx_nx = row_idx + 2'd1;
                    dwell_nx   = '0;
                    db_nx      = '0;
                    state_nx   = SCAN;
                end else begin
                    db_nx = db_cnt + 1'b1;
                end
            end
            default: state_nx = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_m     <= 4'b1111;
            col_s     <= 4'b1111;
            state     <= SCAN;
            row_idx   <= 2'd0;
            dwell_cnt <= '0;
            db_cnt    <= '0;
            cand      <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            col_m     <= col;
            col_s     <= col_m;
            state     <= state_nx;
            row_idx   <= row_idx_nx;
            dwell_cnt <= dwell_nx;
            db_cnt    <= db_nx;
            cand      <= cand_nx;
            key_code  <= code_nx;
            key_valid <= valid_nx;
            key_held  <= held_nx;
        end
    end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed and randomized bench for keypad_scan_debounce with a small keypad matrix model
// and a queue of expected key codes consumed on every strobe.
module tb_keypad_scan_debounce;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    always #5 clk = ~clk;

    keypad_scan_debounce #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .col(col), .row(row),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    // Keypad matrix: a closed switch pulls its column low only while its row is driven low.
    logic       key_down = 1'b0;
    logic [1:0] key_r = 2'd0, key_c = 2'd0;
    logic       multi = 1'b0;
    logic [1:0] multi_r = 2'd0;

    always_comb begin
        col = 4'b1111;
        if (multi && row[multi_r] == 1'b0) col = 4'b1001;
        else if (key_down && row[key_r] == 1'b0) col[key_c] = 1'b0;
    end

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         valid_cnt = 0;
    int         last_valid_cyc = -1;
    logic       prev_valid = 1'b0;
    logic [3:0] exp_q[$];

    function automatic logic [3:0] row_of(input int idx);
        return ~(4'b0001 << (idx % 4));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample #1 after the edge and settle every strobe against the expected queue.
    task automatic step();
        logic [3:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (key_valid === 1'b1) begin
            check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = 4'hx;
            check("key_code", 32'(key_code), 32'(e));
            check("strobe_not_back_to_back", 32'(prev_valid), 32'd0);
            valid_cnt++;
            last_valid_cyc = cyc;
        end
        prev_valid = key_valid;
    endtask

    task automatic wait_row(input int idx, input int budget, output int at);
        int n = 0;
        while (row !== row_of(idx) && n < budget) begin
            step();
            n++;
        end
        check("wait_row", 32'(row), 32'(row_of(idx)));
        at = cyc;
    endtask

    task automatic wait_valid(input int budget);
        int start = valid_cnt;
        int n = 0;
        while (valid_cnt == start && n < budget) begin
            step();
            n++;
        end
        check("valid_seen", 32'(valid_cnt - start), 32'd1);
    endtask

    task automatic do_press(input int r, input int c);
        int t, x;
        wait_row((r + 1) % 4, 24, t);
        key_r    = 2'(r);
        key_c    = 2'(c);
        key_down = 1'b1;
        exp_q.push_back(4'(r * 4 + c));
        wait_row(r, 24, x);
        wait_valid(40);
        check("press_latency", 32'(last_valid_cyc - x), 32'(SCAN_DIV + DEB));
        check("held_after_press", 32'(key_held), 32'd1);
    endtask

    task automatic do_release();
        logic [3:0] code_before = key_code;
        key_down = 1'b0;
        for (int k = 1; k <= DEB + 2; k++) begin
            step();
            check("held_during_release", 32'(key_held), 32'd1);
        end
        step();
        check("held_dropped", 32'(key_held), 32'd0);
        check("row_after_release", 32'(row), 32'(row_of(int'(key_r) + 1)));
        check("code_kept", 32'(key_code), 32'(code_before));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, x, r0, start, n, p, g;

        // Reset with no keys, then watch the rows rotate.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset_row", 32'(row), 32'h0e);
        check("reset_code", 32'(key_code), 32'd0);
        check("reset_valid", 32'(key_valid), 32'd0);
        check("reset_held", 32'(key_held), 32'd0);
        for (int k = 1; k < 32; k++) begin
            step();
            check("row_rotation", 32'(row), 32'(row_of(k / SCAN_DIV)));
        end
        check("idle_no_strobe", 32'(valid_cnt), 32'd0);
        check("idle_code", 32'(key_code), 32'd0);

        // Clean press on row 2 / col 1 -> code 9; row must stay put while held.
        do_press(2, 1);
        repeat (10) step();
        check("row_locked_while_held", 32'(row), 32'(row_of(2)));
        do_release();

        // Bouncy press on row 0 / col 3.
        key_r = 2'd0;
        key_c = 2'd3;
        exp_q.push_back(4'd3);
        start = valid_cnt;
        for (int i = 0; i < 20; i++) begin
            key_down = ((i / 3) % 2 == 0);
            step();
        end
        check("bounce_no_strobe", 32'(valid_cnt - start), 32'd0);
        key_down = 1'b1;
        wait_valid(60);
        check("bounce_held", 32'(key_held), 32'd1);
        do_release();

        // Hold key 5 with short release glitches: one strobe only, held never drops.
        do_press(1, 1);
        start = valid_cnt;
        n = 0;
        while (n < 100) begin
            p = $urandom_range(2, 10);
            key_down = 1'b1;
            repeat (p) begin
                step();
                check("glitch_held", 32'(key_held), 32'd1);
            end
            g = $urandom_range(1, DEB - 2);
            key_down = 1'b0;
            repeat (g) begin
                step();
                check("glitch_held", 32'(key_held), 32'd1);
            end
            n += p + g;
        end
        key_down = 1'b1;
        repeat (4) step();
        check("glitch_no_repeat", 32'(valid_cnt - start), 32'd0);
        do_release();

        // Two columns low on row 1: rejected, scanning moves on.
        wait_row(2, 24, t);
        multi_r = 2'd1;
        multi   = 1'b1;
        start   = valid_cnt;
        wait_row(1, 24, x);
        repeat (SCAN_DIV - 1) step();
        check("multi_row_dwell", 32'(row), 32'(row_of(1)));
        step();
        check("multi_row_advance", 32'(row), 32'(row_of(2)));
        repeat (16) step();
        check("multi_no_strobe", 32'(valid_cnt - start), 32'd0);
        multi = 1'b0;

        // Reset in the middle of a press debounce, then a fresh full debounce.
        wait_row(0, 24, t);
        key_r    = 2'd3;
        key_c    = 2'd0;
        key_down = 1'b1;
        wait_row(3, 24, x);
        repeat (SCAN_DIV + 5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        r0 = cyc;
        check("midreset_row", 32'(row), 32'h0e);
        check("midreset_held", 32'(key_held), 32'd0);
        check("midreset_code", 32'(key_code), 32'd0);
        check("midreset_valid", 32'(key_valid), 32'd0);
        exp_q.push_back(4'd12);
        wait_valid(60);
        check("midreset_latency", 32'(last_valid_cyc - r0), 32'(4 * SCAN_DIV + DEB));
        do_release();

        // Random single keys.
        repeat (4) begin
            int rr, cc;
            rr = $urandom_range(0, 3);
            cc = $urandom_range(0, 3);
            do_press(rr, cc);
            repeat ($urandom_range(0, 10)) step();
            do_release();
        end

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
